ice_bram_fifo: RTL and testbench

// Parametrised single-clock synchronous FIFO on iCE40 block RAM, generalising
// the fixed 256x16 BRAM primitive wrapper into a buffered stream element.

---
 rtl/ice_bram_fifo.sv | 130 +++++++++++++
 tb/tb_ice_bram_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ice_bram_fifo.sv
// Single-clock FIFO on inferred dual-port block RAM.
// Registered flags, sticky error bits, 1-cycle read latency.
module ice_bram_fifo #(
    parameter int WIDTH         = 16,
    parameter int DEPTH_LOG2    = 8,
    parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef logic [CW-1:0]         cnt_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    localparam cnt_t FULL_CNT   = cnt_t'(DEPTH);
    localparam cnt_t AFULL_CNT  = cnt_t'(AFULL_THRESH);
    localparam cnt_t AEMPTY_CNT = cnt_t'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_word_q;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;
    logic rd_valid_q, rd_valid_d;
    logic rd_seen_q, rd_seen_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    logic wr_acc;
    logic rd_acc;

    always_comb begin
        wr_acc     = wr_en && !full_q;
        rd_acc     = rd_en && !empty_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + cnt_t'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - cnt_t'(1);
        end
        // Flags are registered from the next count, so they track count_q.
        full_d     = (count_d == FULL_CNT);
        empty_d    = (count_d == '0);
        afull_d    = (count_d >= AFULL_CNT);
        aempty_d   = (count_d <= AEMPTY_CNT);
        rd_valid_d = rd_acc;
        rd_seen_d  = rd_seen_q || rd_acc;
        ovf_d      = ovf_q || (wr_en && full_q);
        unf_d      = unf_q || (rd_en && empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            rd_valid_q <= rd_valid_d;
            rd_seen_q  <= rd_seen_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Reset-free storage and read register so the array maps onto BRAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (rd_acc && !rst) begin
            rd_word_q <= mem[rd_ptr_q];
        end
    end

    // Until the first read after reset the stale RAM register is masked to 0.
    assign rd_data      = rd_seen_q ? rd_word_q : '0;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_ice_bram_fifo.sv
// Directed self-checking bench for ice_bram_fifo.
// Default parameters: 16-bit words, 256 deep.
module tb_ice_bram_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        almost_full;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        almost_empty;
    logic [8:0]  count;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb [$];
    logic [15:0] exp_w;

    ice_bram_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        // 1: reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdv", 32'(rd_valid), 0);
        chk("rst_rdata", 32'(rd_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // 2: five words in, five out
        for (int i = 1; i <= 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'(i);
            step();
            chk("wr_count", 32'(count), 32'(i));
            chk("wr_aempty", 32'(almost_empty), (i <= 4) ? 1 : 0);
        end
        wr_en = 1'b0;
        chk("wr_empty", 32'(empty), 0);
        for (int i = 1; i <= 5; i++) begin
            rd_en = 1'b1;
            step();
            chk("rd_valid", 32'(rd_valid), 1);
            chk("rd_data", 32'(rd_data), 32'(i));
            chk("rd_count", 32'(count), 32'(5 - i));
        end
        rd_en = 1'b0;
        step();
        chk("rd_idle_valid", 32'(rd_valid), 0);
        chk("rd_hold_data", 32'(rd_data), 5);
        chk("rd_end_empty", 32'(empty), 1);

        // 3: fill to DEPTH, then overflow
        for (int i = 0; i < 256; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0100 + 16'(i);
            step();
            if (i == 250) chk("afull_251", 32'(almost_full), 0);
            if (i == 251) chk("afull_252", 32'(almost_full), 1);
            if (i == 254) chk("full_255", 32'(full), 0);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 256);
        chk("fill_ovf", 32'(overflow), 0);
        wr_data = 16'hDEAD;
        step();
        chk("ovf_count", 32'(count), 256);
        chk("ovf_set", 32'(overflow), 1);

        // 4: simultaneous request when full, drain, then when empty
        rd_en   = 1'b1;
        wr_data = 16'hBEEF;
        step();
        wr_en = 1'b0;
        chk("fullrw_count", 32'(count), 255);
        chk("fullrw_valid", 32'(rd_valid), 1);
        chk("fullrw_data", 32'(rd_data), 32'h0100);
        chk("fullrw_ovf", 32'(overflow), 1);
        chk("fullrw_full", 32'(full), 0);
        for (int i = 1; i < 256; i++) begin
            step();
            chk("drain_data", 32'(rd_data), 32'h0100 + 32'(i));
        end
        rd_en = 1'b0;
        step();
        chk("drain_empty", 32'(empty), 1);
        chk("drain_unf", 32'(underflow), 0);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'h1234;
        step();
        wr_en = 1'b0;
        chk("emptyrw_count", 32'(count), 1);
        chk("emptyrw_valid", 32'(rd_valid), 0);
        chk("emptyrw_unf", 32'(underflow), 1);
        step();
        rd_en = 1'b0;
        chk("emptyrw_data", 32'(rd_data), 32'h1234);
        chk("emptyrw_rdv", 32'(rd_valid), 1);
        chk("emptyrw_cnt0", 32'(count), 0);

        // 5: streaming at half occupancy with pointer wrap
        for (int i = 0; i < 128; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h5000 + 16'(i);
            sb.push_back(wr_data);
            step();
        end
        rd_en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            wr_data = 16'h8000 + 16'(c);
            step();
            exp_w = sb.pop_front();
            sb.push_back(wr_data);
            chk("stream_data", 32'(rd_data), 32'(exp_w));
            if (c == 500) chk("stream_count", 32'(count), 128);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        chk("stream_end_cnt", 32'(count), 128);

        // 6: reset mid-stream overrides pending traffic
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h7700 + 16'(i);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        chk("pre_rst_valid", 32'(rd_valid), 1);
        chk("pre_rst_count", 32'(count), 9);
        rst   = 1'b1;
        wr_en = 1'b1;
        step();
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_data", 32'(rd_data), 0);
        wr_en   = 1'b1;
        wr_data = 16'hAAAA;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("post_rst_data", 32'(rd_data), 32'hAAAA);
        chk("post_rst_valid", 32'(rd_valid), 1);
        step();
        chk("post_rst_empty", 32'(empty), 1);
        chk("post_rst_unf", 32'(underflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
